// File: rtl/waveform_plotter.sv
// Waveform trace renderer for a 160x120 plot adapter: paints the axis after reset,
// then on each frame request erases the old trace pixel and plots the new one per column.
module waveform_plotter #(
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter int         Y_CENTER     = 60,
    parameter int         DATA_W       = 32,
    parameter logic [2:0] TRACE_COLOUR = 3'b010,
    parameter logic [2:0] AXIS_COLOUR  = 3'b001,
    parameter logic [2:0] BG_COLOUR    = 3'b000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     iFrameTick,
    input  logic                     iHold,
    input  logic signed [DATA_W-1:0] iY,
    output logic [7:0]               oX,
    output logic [7:0]               oVGA_x,
    output logic [6:0]               oVGA_y,
    output logic [2:0]               oVGA_colour,
    output logic                     oVGA_plot,
    output logic                     oBusy,
    output logic                     oFrameDone
);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ERASE, S_FETCH, S_DRAW} state_t;

    localparam logic [7:0] LAST_COL = 8'(SCREEN_W - 1);
    localparam logic [6:0] ROW_END  = 7'(SCREEN_H);
    localparam logic [6:0] AXIS_ROW = 7'(Y_CENTER);
    localparam logic signed [DATA_W-1:0] Y_TOP = DATA_W'(Y_CENTER);
    localparam logic signed [DATA_W-1:0] Y_BOT = DATA_W'(Y_CENTER - (SCREEN_H - 1));

    state_t     state, state_d;
    logic [7:0] col, col_d, next_col, x_d, vx_d;
    logic [6:0] row, row_d, vy_d;
    logic [2:0] vc_d;
    logic       pending, pending_d, plot_d, done_d;
    logic [6:0] old_row [SCREEN_W];

    // Compare against the bounds first so extreme samples cannot overflow the subtraction.
    function automatic logic [6:0] sample_to_row(input logic signed [DATA_W-1:0] y);
        if (y > Y_TOP)      return '0;
        else if (y < Y_BOT) return 7'(SCREEN_H - 1);
        else                return 7'(Y_TOP - y);
    endfunction

    function automatic logic [2:0] erase_colour(input logic [6:0] r);
        return (r == AXIS_ROW) ? AXIS_COLOUR : BG_COLOUR;
    endfunction

    assign next_col = col + 8'd1;
    assign oBusy    = (state != S_IDLE);

    always_comb begin
        state_d   = state;
        col_d     = col;
        row_d     = row;
        pending_d = pending;
        x_d       = oX;
        vx_d      = '0;
        vy_d      = '0;
        vc_d      = BG_COLOUR;
        plot_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state)
            // Row counter reaching SCREEN_H marks the raster as complete.
            S_INIT: begin
                pending_d = pending | iFrameTick;
                if (row < ROW_END) begin
                    plot_d = 1'b1;
                    vx_d   = col;
                    vy_d   = row;
                    vc_d   = erase_colour(row);
                    if (col == LAST_COL) begin
                        col_d = '0;
                        row_d = row + 7'd1;
                    end else begin
                        col_d = next_col;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (iHold) begin
                    pending_d = 1'b0;
                end else if (iFrameTick || pending) begin
                    state_d   = S_ERASE;
                    col_d     = '0;
                    pending_d = 1'b0;
                    plot_d    = 1'b1;
                    vx_d      = '0;
                    vy_d      = old_row[0];
                    vc_d      = erase_colour(old_row[0]);
                end
            end
            S_ERASE: begin
                pending_d = pending | iFrameTick;
                x_d       = col;
                state_d   = S_FETCH;
            end
            S_FETCH: begin
                pending_d = pending | iFrameTick;
                state_d   = S_DRAW;
                plot_d    = 1'b1;
                vx_d      = col;
                vy_d      = sample_to_row(iY);
                vc_d      = TRACE_COLOUR;
                done_d    = (col == LAST_COL);
            end
            S_DRAW: begin
                pending_d = pending | iFrameTick;
                if (col == LAST_COL) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ERASE;
                    col_d   = next_col;
                    plot_d  = 1'b1;
                    vx_d    = next_col;
                    vy_d    = old_row[next_col];
                    vc_d    = erase_colour(old_row[next_col]);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state       <= S_INIT;
            col         <= '0;
            row         <= '0;
            pending     <= 1'b0;
            oX          <= '0;
            oVGA_x      <= '0;
            oVGA_y      <= '0;
            oVGA_colour <= '0;
            oVGA_plot   <= 1'b0;
            oFrameDone  <= 1'b0;
            for (int i = 0; i < SCREEN_W; i++) old_row[i] <= AXIS_ROW;
        end else begin
            state       <= state_d;
            col         <= col_d;
            row         <= row_d;
            pending     <= pending_d;
            oX          <= x_d;
            oVGA_x      <= vx_d;
            oVGA_y      <= vy_d;
            oVGA_colour <= vc_d;
            oVGA_plot   <= plot_d;
            oFrameDone  <= done_d;
            if (state == S_DRAW) old_row[col] <= oVGA_y;
        end
    end
endmodule
